lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit controller for an 8-bit-addressed data_mem.
// Misaligned accesses are split into byte beats.
`default_nettype none

module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wval,
  input  logic [31:0] mem_rval
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic        r_store;
  logic [2:0]  r_funct3;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_misal;
  logic [2:0]  r_size;
  logic [1:0]  r_beat;
  logic        r_fault;
  logic [31:0] r_rdata;

  logic        w_legal;
  logic [2:0]  w_size;
  logic        w_misal;
  logic [8:0]  w_end;
  logic        w_fault;
  logic        w_last;
  logic [31:0] w_merge;
  logic [31:0] w_cap;

  // Request decode, evaluated on the incoming request while in IDLE
  always_comb begin
    w_legal = 1'b0;
    if (req_store) begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    case (req_funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
    w_misal = (req_addr[1:0] & (w_size[1:0] - 2'd1)) != 2'b00;
    w_end   = {1'b0, req_addr[7:0]} + {6'b0, w_size} - 9'd1;
    w_fault = !w_legal || (req_addr[31:8] != 24'd0) || (w_end > 9'h0FF);
  end

  always_comb begin
    w_last  = !r_misal || ({1'b0, r_beat} == (r_size - 3'd1));
    w_merge = r_rdata | ({24'b0, mem_rval[7:0]} << {r_beat, 3'b000});
    if (!r_misal) begin
      w_cap = mem_rval;
    end else if (w_last && (r_funct3 == 3'b001)) begin
      w_cap = {{16{w_merge[15]}}, w_merge[15:0]};
    end else begin
      w_cap = w_merge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_next = w_fault ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!r_store) begin
          w_state_next = S_CAPTURE;
        end else if (w_last) begin
          w_state_next = S_RESP;
        end
      end
      S_CAPTURE: w_state_next = w_last ? S_RESP : S_ISSUE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 8'd0;
      r_wdata  <= 32'd0;
      r_misal  <= 1'b0;
      r_size   <= 3'd0;
      r_beat   <= 2'd0;
      r_fault  <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[7:0];
            r_wdata  <= req_wdata;
            r_misal  <= w_misal;
            r_size   <= w_size;
            r_beat   <= 2'd0;
            r_fault  <= w_fault;
            r_rdata  <= 32'd0;
          end
        end
        S_ISSUE: begin
          if (r_store && !w_last) begin
            r_beat <= r_beat + 2'd1;
          end
        end
        S_CAPTURE: begin
          r_rdata <= w_cap;
          if (!w_last) begin
            r_beat <= r_beat + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side signals are only non-zero during ISSUE so reset forces them low at once
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = 8'd0;
    mem_wval   = 32'd0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    resp_rdata = 32'd0;
    case (r_state)
      S_ISSUE: begin
        mem_read  = !r_store;
        mem_write = r_store;
        if (r_misal) begin
          mem_funct3 = r_store ? 3'b000 : 3'b100;
          mem_addr   = r_addr + {6'b0, r_beat};
          mem_wval   = r_store ? {24'b0, r_wdata[{r_beat, 3'b000} +: 8]} : 32'd0;
        end else begin
          mem_funct3 = r_funct3;
          mem_addr   = r_addr;
          mem_wval   = r_store ? r_wdata : 32'd0;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_fault = r_fault;
        resp_rdata = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
